// File: rtl/bram_row_pingpong_pkg.sv
// rtl/bram_row_pingpong_pkg.sv - shared bank-state encoding and width helper for the ping-pong row store
package bram_row_pingpong_pkg;

  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  function automatic int clog2_fn(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bram_row_bank.sv
// rtl/bram_row_bank.sv - one row bank: synchronous write, registered read, array left unreset
module bram_row_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bram_row_pingpong.sv
// rtl/bram_row_pingpong.sv - double-buffered row store; one bank fills while the other is replayed
module bram_row_pingpong
  import bram_row_pingpong_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int READ_PASSES = 1,
  parameter int PASS_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_bank_done,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic                  rd_bank_done,
  output logic [1:0]            banks_full
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PASS_WIDTH-1:0] PASS_LAST = PASS_WIDTH'(READ_PASSES - 1);

  generate
    if (ADDR_WIDTH != clog2_fn(DEPTH) || (1 << PASS_WIDTH) < READ_PASSES || DEPTH < 2) begin : g_bad_params
      $error("bram_row_pingpong: inconsistent DEPTH/ADDR_WIDTH/READ_PASSES/PASS_WIDTH");
    end
  endgenerate

  logic [1:0][1:0]       st_q, st_d;
  logic                  wr_bank_q, rd_bank_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [PASS_WIDTH-1:0] pass_q;
  logic                  wr_overflow_q, wr_bank_done_q;
  logic                  rd_valid_q, rd_last_q, rd_bank_done_q;
  logic [1:0]            banks_full_q;
  logic                  rd_sel_q, has_data_q;
  logic [DATA_WIDTH-1:0] q0, q1;

  logic wr_acc, rd_acc, wr_row_end, rd_row_end, rd_release;

  assign wr_acc     = wr_en & wr_ready & ~flush;
  assign rd_acc     = rd_en & rd_ready & ~flush;
  assign wr_row_end = wr_acc & (wr_ptr_q == PTR_LAST);
  assign rd_row_end = rd_acc & (rd_ptr_q == PTR_LAST);
  assign rd_release = rd_row_end & (pass_q == PASS_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= {ST_EMPTY, ST_EMPTY};
    else        st_q <= st_d;
  end

  // Next state: the two accepts always target different banks, so both updates can apply together
  always_comb begin
    st_d = st_q;
    if (wr_acc) st_d[wr_bank_q] = wr_row_end ? ST_FULL : ST_FILLING;
    if (rd_acc) st_d[rd_bank_q] = rd_release ? ST_EMPTY : ST_DRAINING;
    if (flush)  st_d = {ST_EMPTY, ST_EMPTY};
  end

  // Handshake outputs; the release pulse holds off the next bank for exactly one cycle
  always_comb begin
    wr_ready = (st_q[wr_bank_q] == ST_EMPTY) || (st_q[wr_bank_q] == ST_FILLING);
    rd_ready = ((st_q[rd_bank_q] == ST_FULL) || (st_q[rd_bank_q] == ST_DRAINING)) && !rd_bank_done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pass_q         <= '0;
      wr_overflow_q  <= 1'b0;
      wr_bank_done_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_bank_done_q <= 1'b0;
      banks_full_q   <= 2'd0;
      rd_sel_q       <= 1'b0;
      has_data_q     <= 1'b0;
    end else if (flush) begin
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pass_q         <= '0;
      wr_overflow_q  <= 1'b0;
      wr_bank_done_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_bank_done_q <= 1'b0;
      banks_full_q   <= 2'd0;
      rd_sel_q       <= 1'b0;
      has_data_q     <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_row_end ? '0 : wr_ptr_q + 1'b1;
        if (wr_row_end) wr_bank_q <= ~wr_bank_q;
      end
      if (wr_en && !wr_ready) wr_overflow_q <= 1'b1;
      if (rd_acc) begin
        rd_ptr_q   <= rd_row_end ? '0 : rd_ptr_q + 1'b1;
        rd_sel_q   <= rd_bank_q;
        has_data_q <= 1'b1;
      end
      if (rd_row_end) pass_q <= rd_release ? '0 : pass_q + 1'b1;
      if (rd_release) rd_bank_q <= ~rd_bank_q;
      wr_bank_done_q <= wr_row_end;
      rd_valid_q     <= rd_acc;
      rd_last_q      <= rd_row_end;
      rd_bank_done_q <= rd_release;
      banks_full_q   <= {1'b0, st_d[0][1]} + {1'b0, st_d[1][1]};
    end
  end

  bram_row_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
    .clk    (clk),
    .wr_en  (wr_acc & ~wr_bank_q),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_en  (rd_acc & ~rd_bank_q),
    .rd_addr(rd_ptr_q),
    .rd_data(q0)
  );

  bram_row_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
    .clk    (clk),
    .wr_en  (wr_acc & wr_bank_q),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_en  (rd_acc & rd_bank_q),
    .rd_addr(rd_ptr_q),
    .rd_data(q1)
  );

  // Bank outputs only change on a read of that bank, so selecting the last-read bank holds rd_data
  assign rd_data      = has_data_q ? (rd_sel_q ? q1 : q0) : '0;
  assign rd_valid     = rd_valid_q;
  assign rd_last      = rd_last_q;
  assign rd_bank_done = rd_bank_done_q;
  assign wr_bank_done = wr_bank_done_q;
  assign wr_overflow  = wr_overflow_q;
  assign banks_full   = banks_full_q;

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(wr_ptr_q) < DEPTH) && (32'(rd_ptr_q) < DEPTH));
  a_one_filling: assert property (@(posedge clk) disable iff (!rst_n)
    !((st_q[0] == ST_FILLING) && (st_q[1] == ST_FILLING)));
  a_valid_src: assert property (@(posedge clk) disable iff (!rst_n)
    rd_valid_q |-> $past(rd_acc));

endmodule
